// File: rtl/slow_event_arbiter.sv
// Queues fast-domain request edges and hands them one at a time to a slow
// consumer, holding each strobe until a synchronized slowClk rise is seen.
// Ports:
//   clk, reset  fast clock, synchronous active-high reset
//   req         per-requester event inputs (rising edge = one event)
//   slowClk     slow-domain clock, sampled as data
//   out,out_id  event strobe and index of the requester being presented
//   pending     captured events not yet granted
//   dropped     sticky flag: event arrived while already pending
module slow_event_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             slowClk,
  output logic             out,
  output logic [ID_W-1:0]  out_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] dropped
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH,
    GAP_LOW,
    GAP_HIGH
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             s_q;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] dropped_q;
  logic [N_REQ-1:0] dropped_d;
  logic [N_REQ-1:0] ev;
  logic [N_REQ-1:0] gnt_mask;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  scan_idx;
  logic [ID_W-1:0]  out_id_q;
  logic             out_q;
  logic             gnt_any;
  logic             grant;

  assign ev = req & ~req_q;

  // Round-robin scan starting at rr_ptr, wrapping at N_REQ.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = rr_ptr_q;
    for (int j = 0; j < N_REQ; j++) begin
      if (!gnt_any && pending_q[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
      scan_idx = (scan_idx == ID_W'(N_REQ - 1)) ?
                 '0 : scan_idx + ID_W'(1);
    end
  end

  assign grant = (state_q == IDLE) && gnt_any;
  assign gnt_mask = grant ? (N_REQ'(1) << gnt_idx) : '0;

  // A new edge on the granted index re-arms it instead of dropping.
  always_comb begin
    pending_d = (pending_q & ~gnt_mask) | ev;
    dropped_d = dropped_q | (ev & pending_q & ~gnt_mask);
    rr_ptr_d  = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ?
                 '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      req_q     <= '0;
      pending_q <= '0;
      dropped_q <= '0;
      rr_ptr_q  <= '0;
      out_q     <= 1'b0;
      out_id_q  <= '0;
    end else begin
      sync1_q   <= slowClk;
      s_q       <= sync1_q;
      req_q     <= req;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      rr_ptr_q  <= rr_ptr_d;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            out_q    <= 1'b1;
            out_id_q <= gnt_idx;
            state_q  <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!s_q) state_q <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (s_q) begin
            out_q   <= 1'b0;
            state_q <= GAP_LOW;
          end
        end
        GAP_LOW: begin
          if (!s_q) state_q <= GAP_HIGH;
        end
        GAP_HIGH: begin
          if (s_q) state_q <= IDLE;
        end
        default: begin
          out_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign out_id  = out_id_q;
  assign pending = pending_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_slow_event_arbiter.sv
// Self-checking bench for slow_event_arbiter: vector table, directed
// corner sequences and a randomized run against a reference model.
module tb_slow_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic         slowClk = 1'b0;
  logic         out;
  logic [1:0]   out_id;
  logic [N-1:0] pending;
  logic [N-1:0] dropped;

  slow_event_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .slowClk(slowClk),
    .out(out), .out_id(out_id), .pending(pending), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // slow clock generator state
  bit sclk_run = 0;
  int sclk_half = 5;
  int sclk_cnt = 0;

  // observation of grants
  int       grants = 0;
  int       ids[$];
  logic     prev_out = 0;
  logic     prev_sclk = 0;
  int       gap_rises = 0;
  int       min_gap = 1000;
  bit       use_model = 0;

  // reference model: an event lives through four slow-level waits
  // (low, high while strobing; low, high while gapping)
  logic [N-1:0] m_pend, m_drop, m_prev;
  int           m_rr, m_waits, m_id;
  bit           hist[$];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_drop = '0; m_prev = '0;
    m_rr = 0; m_waits = 0; m_id = 0;
    hist = {1'b0, 1'b0};
  endtask

  task automatic model_step();
    bit s;
    int g;
    logic [N-1:0] ev;
    if (reset) begin
      model_reset();
      return;
    end
    s = hist.pop_front();
    hist.push_back(slowClk);
    ev = req & ~m_prev;
    m_prev = req;
    g = -1;
    if (m_waits == 0) begin
      for (int j = 0; j < N; j++) begin
        int k;
        k = (m_rr + j) % N;
        if (g < 0 && m_pend[k]) g = k;
      end
      if (g >= 0) begin
        m_waits = 4;
        m_id = g;
        m_rr = (g + 1) % N;
      end
    end else if (s == (m_waits % 2 == 1)) begin
      m_waits--;
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i]) begin
        if (m_pend[i] && i != g) m_drop[i] = 1'b1;
        m_pend[i] = 1'b1;
      end else if (i == g) begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    logic [31:0] act, exp;
    bit mout;
    if (sclk_run) begin
      sclk_cnt++;
      if (sclk_cnt >= sclk_half) begin
        sclk_cnt = 0;
        slowClk = ~slowClk;
      end
    end
    @(posedge clk);
    model_step();
    #1;
    if (use_model) begin
      mout = (m_waits >= 3);
      act = {19'd0, out, (out ? out_id : 2'd0), pending, dropped};
      exp = {19'd0, mout, (mout ? 2'(m_id) : 2'd0), m_pend, m_drop};
      chk("model", act, exp);
    end
    if (!out && slowClk && !prev_sclk) gap_rises++;
    if (out && !prev_out) begin
      if (grants > 0 && gap_rises < min_gap) min_gap = gap_rises;
      grants++;
      ids.push_back(int'(out_id));
      gap_rises = 0;
    end
    prev_out = out;
    prev_sclk = slowClk;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    run(2);
    reset = 1'b0;
    grants = 0;
    ids.delete();
    min_gap = 1000;
    gap_rises = 0;
  endtask

  task automatic pulse(logic [N-1:0] v);
    req = v;
    cyc();
    req = '0;
    cyc();
  endtask

  task automatic wait_grants(int n, int maxc, string nm);
    int c;
    c = 0;
    while (grants < n && c < maxc) begin
      cyc();
      c++;
    end
    chk(nm, grants, n);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] rq;
    logic         sc;
    logic         eout;
    logic [1:0]   eid;
    logic [N-1:0] epend;
    logic [N-1:0] edrop;
  } vec_t;

  vec_t tbl[17];

  initial begin
    model_reset();
    tbl[0]  = '{1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000};
    tbl[1]  = '{0, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000};
    tbl[2]  = '{0, 4'b0100, 0, 1, 2, 4'b0000, 4'b0000};
    tbl[3]  = '{0, 4'b0000, 0, 1, 2, 4'b0000, 4'b0000};
    tbl[4]  = '{0, 4'b0000, 1, 1, 2, 4'b0000, 4'b0000};
    tbl[5]  = '{0, 4'b0000, 1, 1, 2, 4'b0000, 4'b0000};
    tbl[6]  = '{0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000};
    tbl[7]  = '{0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000};
    tbl[8]  = '{0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000};
    tbl[9]  = '{0, 4'b0010, 0, 0, 0, 4'b0010, 4'b0000};
    tbl[10] = '{0, 4'b0000, 1, 0, 0, 4'b0010, 4'b0000};
    tbl[11] = '{0, 4'b0010, 1, 0, 0, 4'b0010, 4'b0010};
    tbl[12] = '{0, 4'b0000, 1, 0, 0, 4'b0010, 4'b0010};
    tbl[13] = '{0, 4'b0000, 1, 1, 1, 4'b0000, 4'b0010};
    tbl[14] = '{0, 4'b0000, 1, 1, 1, 4'b0000, 4'b0010};
    tbl[15] = '{1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000};
    tbl[16] = '{0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000};

    for (int i = 0; i < 17; i++) begin
      logic [31:0] act, exp;
      reset = tbl[i].rst;
      req = tbl[i].rq;
      slowClk = tbl[i].sc;
      cyc();
      act = {21'd0, out, (out ? out_id : 2'd0), pending, dropped};
      exp = {21'd0, tbl[i].eout, tbl[i].eid, tbl[i].epend, tbl[i].edrop};
      chk($sformatf("table row %0d", i), act, exp);
    end

    use_model = 1;

    // three simultaneous events, round robin from 0
    slowClk = 0; sclk_run = 1; sclk_half = 5; sclk_cnt = 0;
    do_reset();
    pulse(4'b1011);
    wait_grants(3, 400, "rr grant count");
    run(60);
    chk("rr id0", (ids.size() > 0) ? ids[0] : 99, 0);
    chk("rr id1", (ids.size() > 1) ? ids[1] : 99, 1);
    chk("rr id2", (ids.size() > 2) ? ids[2] : 99, 3);
    chk("rr gap has slow rise", (min_gap >= 1), 1);
    chk("rr idle pending", pending, 0);

    // level held 50 cycles = one event
    do_reset();
    req = 4'b0010;
    run(50);
    req = '0;
    run(80);
    chk("hold grants", grants, 1);
    chk("hold id", (ids.size() > 0) ? ids[0] : 99, 1);
    chk("hold dropped", dropped, 0);

    // repeated pulses while pending -> dropped, sticky
    sclk_run = 0; slowClk = 0;
    do_reset();
    pulse(4'b0001);
    run(3);
    pulse(4'b0010);
    chk("drop pending1", pending[1], 1);
    pulse(4'b0010);
    pulse(4'b0010);
    chk("drop flag", dropped, 4'b0010);
    sclk_run = 1;
    wait_grants(2, 400, "drop grant count");
    run(150);
    chk("drop grants total", grants, 2);
    chk("drop second id", (ids.size() > 1) ? ids[1] : 99, 1);
    chk("drop sticky", dropped, 4'b0010);

    // slowClk stopped high while waiting for low
    sclk_run = 0; slowClk = 1;
    do_reset();
    run(3);
    pulse(4'b0100);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        cyc();
        if (out !== 1'b1) bad++;
      end
      chk("stall out held", bad, 0);
    end
    sclk_run = 1; sclk_cnt = 0;
    begin
      int c;
      c = 0;
      while (out && c < 200) begin
        cyc();
        c++;
      end
      chk("stall released", out, 0);
    end
    run(60);
    chk("stall grants", grants, 1);
    chk("stall pending", pending, 0);

    // reset mid-grant discards queue
    sclk_run = 0; slowClk = 0;
    do_reset();
    pulse(4'b0001);
    run(5);
    pulse(4'b1010);
    chk("midrst pending", pending, 4'b1010);
    chk("midrst out busy", out, 1);
    reset = 1'b1;
    cyc();
    chk("midrst out", out, 0);
    chk("midrst pend", pending, 0);
    reset = 1'b0;
    grants = 0;
    sclk_run = 1;
    run(60);
    chk("midrst no grant", grants, 0);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        sclk_run = ($urandom_range(0, 4) != 0);
        sclk_half = $urandom_range(1, 7);
      end
      reset = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      cyc();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
